aes_key_sched_ctrl: RTL and testbench

//  Sequences the byte-wide round-key ROM (11 keys x 16 B, addr = 16*round + byte) for the iterative AES core.

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_rk_assembler.sv | 28 ++
 rtl/aes_key_sched_ctrl.sv | 114 +++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES round-key fetch sequencer.
package aes_pkg;
    localparam int NUM_ROUNDS = 10;
    localparam int KEY_BYTES  = 16;
    localparam int ADDR_W     = 8;

    typedef logic [127:0] rk_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        OFFER
    } state_t;
endpackage

// File: rtl/aes_rk_assembler.sv
// Byte-slot write register: collects one round key a byte at a time.
// Slot 0 lands in the most significant byte of key_out.
module aes_rk_assembler #(
    parameter int KEY_BYTES = 16,
    parameter int SLOT_W    = $clog2(KEY_BYTES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [SLOT_W-1:0]      slot,
    input  logic [7:0]             byte_in,
    output logic [8*KEY_BYTES-1:0] key_out
);

    for (genvar s = 0; s < KEY_BYTES; s++) begin : g_slot
        logic [7:0] slot_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                slot_q <= '0;
            else if (wr_en && (slot == SLOT_W'(s)))
                slot_q <= byte_in;
        end

        assign key_out[(KEY_BYTES-1-s)*8 +: 8] = slot_q;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Round-key fetch sequencer: walks the byte-wide key ROM one round at a time
// and offers each assembled key on a valid/ready port.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int KEY_BYTES  = aes_pkg::KEY_BYTES,
    parameter int ADDR_W     = aes_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   decrypt,
    input  logic                   abort,
    output logic                   busy,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [7:0]             rom_data,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic [8*KEY_BYTES-1:0] rk_data,
    output logic [3:0]             rk_round,
    output logic                   rk_last,
    output logic                   done
);
    import aes_pkg::*;

    localparam int SLOT_W = $clog2(KEY_BYTES);

    state_t            state, next_state;
    logic [3:0]        round_q;
    logic [SLOT_W-1:0] byte_cnt;
    logic              dec_q;
    logic              done_q;
    logic              last_key;
    logic              handshake;
    logic              slot_full;

    assign last_key  = dec_q ? (round_q == 4'd0) : (round_q == 4'(NUM_ROUNDS));
    assign handshake = (state == OFFER) && rk_ready;
    assign slot_full = (byte_cnt == SLOT_W'(KEY_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // abort outranks everything, including a coincident start or handshake
    always_comb begin
        next_state = state;
        if (abort)
            next_state = IDLE;
        else begin
            case (state)
                IDLE:    if (start)     next_state = FETCH;
                FETCH:   if (slot_full) next_state = OFFER;
                OFFER:   if (handshake) next_state = last_key ? IDLE : FETCH;
                default:                next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q  <= '0;
            byte_cnt <= '0;
            dec_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= handshake && last_key && !abort;
            if (!abort) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            dec_q    <= decrypt;
                            round_q  <= decrypt ? 4'(NUM_ROUNDS) : 4'd0;
                            byte_cnt <= '0;
                        end
                    end
                    FETCH: byte_cnt <= slot_full ? '0 : byte_cnt + 1'b1;
                    OFFER: begin
                        // the final round never steps, so the index cannot wrap
                        if (handshake && !last_key)
                            round_q <= dec_q ? round_q - 1'b1 : round_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy     = (state != IDLE);
        rk_valid = (state == OFFER);
        rk_last  = (state == OFFER) && last_key;
        rom_addr = '0;
        if (state == FETCH)
            rom_addr = ADDR_W'(round_q) * ADDR_W'(KEY_BYTES) + ADDR_W'(byte_cnt);
    end

    assign rk_round = round_q;
    assign done     = done_q;

    aes_rk_assembler #(
        .KEY_BYTES (KEY_BYTES)
    ) u_asm (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   ((state == FETCH) && !abort),
        .slot    (byte_cnt),
        .byte_in (rom_data),
        .key_out (rk_data)
    );

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: ROM contents and expected keys come from an
// AES-128 key expansion of 000102..0F computed here from first principles.
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy, rk_valid, rk_last, done;
    logic [7:0]   rom_addr, rom_data;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [7:0]   rom [0:255];
    logic [127:0] exp_key [0:10];
    logic [127:0] got_key [0:10];

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    aes_key_sched_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .decrypt  (decrypt),
        .abort    (abort),
        .busy     (busy),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .done     (done)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from the field inverse plus the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++)
            if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic build_rom();
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        for (int i = 0; i < 4; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            exp_key[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int j = 0; j < 16; j++) rom[16*r+j] = exp_key[r][127-8*j -: 8];
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs from the edge that launched a fetch until rk_valid; k = negedges waited.
    task automatic wait_key(input int rnd, input bit poke, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start = poke && (k == 5);
            if (k == 1) rk_ready = 1'b0;
            if (!rk_valid && k <= 16) begin
                check("fetch_addr", 128'(rom_addr), 128'(16*rnd + k - 1));
                check("busy_fetch", 128'(busy), 128'(1));
            end
        end while (!rk_valid && k < 40);
        if (!rk_valid) check("key_timeout", 128'(rk_valid), 128'(1));
    endtask

    task automatic run_sweep(input bit dec, input int pct, input bit poke, input int stall_rnd);
        int k;
        int rnd;
        int stall;
        bit take;
        rnd = dec ? 10 : 0;
        for (int i = 0; i < 11; i++) got_key[i] = 'x;
        @(negedge clk);
        start = 1'b1; decrypt = dec; rk_ready = 1'b0;
        for (int n = 0; n < 11; n++) begin
            wait_key(rnd, poke && (n == 2), k);
            check("latency", 128'(k), 128'(17));
            stall = 0;
            while (1) begin
                check("rk_round", 128'(rk_round), 128'(rnd));
                check("rk_data", rk_data, exp_key[rnd]);
                check("rk_last", 128'(rk_last), 128'(n == 10));
                check("addr_offer", 128'(rom_addr), 128'(0));
                check("done_early", 128'(done), 128'(0));
                take = (rnd == stall_rnd && stall < 5) ? 1'b0 :
                       (stall >= 20 || int'($urandom_range(99)) < pct);
                rk_ready = take;
                if (take) break;
                stall++;
                @(negedge clk);
            end
            got_key[rnd] = rk_data;
            if (n == 10) start = poke;
            else rnd = dec ? rnd - 1 : rnd + 1;
        end
        @(negedge clk);
        start = 1'b0; rk_ready = 1'b0;
        check("done_pulse", 128'(done), 128'(1));
        check("busy_end", 128'(busy), 128'(0));
        check("valid_end", 128'(rk_valid), 128'(0));
        @(negedge clk);
        check("done_once", 128'(done), 128'(0));
        check("busy_after", 128'(busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        build_rom();
        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_valid", 128'(rk_valid), 128'(0));
        check("rst_last_done", 128'({rk_last, done}), 128'(0));
        check("rst_data", rk_data, 128'(0));
        check("rst_round_addr", 128'({rk_round, rom_addr}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // encrypt sweep, always ready
        run_sweep(1'b0, 100, 1'b0, -1);
        check("enc_r0", got_key[0], 128'h000102030405060708090A0B0C0D0E0F);
        check("enc_r10", got_key[10], 128'h13111D7FE3944A17F307A78B4D2B30C5);

        // decrypt sweep with random backpressure
        run_sweep(1'b1, 60, 1'b0, -1);
        check("dec_r10", got_key[10], 128'h13111D7FE3944A17F307A78B4D2B30C5);
        check("dec_r9", got_key[9], 128'h549932D1F08557681093ED9CBE2C974E);

        // five-cycle stall on round 1 plus random stalls
        run_sweep(1'b0, 50, 1'b0, 1);
        check("stall_r1", got_key[1], 128'hD6AA74FDD2AF72FADAA678F1D6AB76FE);

        // start pokes mid-fetch and on the final handshake
        run_sweep(1'b0, 100, 1'b1, -1);

        // abort at byte 7 of round 3
        @(negedge clk);
        start = 1'b1; decrypt = 1'b0;
        for (int n = 0; n < 3; n++) begin
            wait_key(n, 1'b0, k);
            rk_ready = 1'b1;
        end
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            rk_ready = 1'b0;
        end
        check("abort_point", 128'(rom_addr), 128'(16*3 + 7));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_addr", 128'(rom_addr), 128'(0));
        for (int j = 0; j < 20; j++) begin
            check("abort_quiet", 128'({busy, rk_valid, done}), 128'(0));
            @(negedge clk);
        end
        run_sweep(1'b0, 100, 1'b0, -1);
        check("post_abort_r0", got_key[0], 128'h000102030405060708090A0B0C0D0E0F);

        // abort and start together in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_vs_start", 128'(busy), 128'(0));

        // abort beats a handshake in OFFER; key register is kept
        start = 1'b1; decrypt = 1'b1;
        wait_key(10, 1'b0, k);
        rk_ready = 1'b1; abort = 1'b1;
        @(negedge clk);
        rk_ready = 1'b0; abort = 1'b0;
        check("abort_offer", 128'({busy, rk_valid, done}), 128'(0));
        check("abort_keep_key", rk_data, exp_key[10]);
        @(negedge clk);
        check("abort_no_done", 128'(done), 128'(0));

        // async reset during round 5 fetch
        start = 1'b1; decrypt = 1'b0;
        for (int n = 0; n < 5; n++) begin
            wait_key(n, 1'b0, k);
            rk_ready = 1'b1;
        end
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            rk_ready = 1'b0;
        end
        check("pre_reset_addr", 128'(rom_addr), 128'(16*5 + 3));
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", 128'({busy, rk_valid, rk_last, done}), 128'(0));
        check("arst_data", rk_data, 128'(0));
        check("arst_round_addr", 128'({rk_round, rom_addr}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1'b0, 100, 1'b0, -1);
        check("post_reset_r0", got_key[0], 128'h000102030405060708090A0B0C0D0E0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
